// File: rtl/refill_arbiter.sv
// refill_arbiter: round-robin I$/D$ line refill onto one burst read port.
// Define REFILL_ARBITER_CRITICAL_WORD_FIRST_EN for wrapping critical-word-first bursts.
module refill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ack,
  input  logic                  ic_cancel,
  output logic                  ic_rvalid,
  output logic [31:0]           ic_rdata,
  output logic [IW-1:0]         ic_ridx,
  output logic                  ic_rlast,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  output logic                  dc_ack,
  output logic                  dc_rvalid,
  output logic [31:0]           dc_rdata,
  output logic [IW-1:0]         dc_ridx,
  output logic                  dc_rlast,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [3:0]            mem_arlen,
  output logic [1:0]            mem_arburst,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rlast,
  output logic                  mem_rready,
  output logic                  busy,
  output logic                  burst_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

  logic [1:0]            state, state_nx;
  logic                  owner_dc, last_dc, drop;
  logic [ADDR_WIDTH-1:0] addr_q, ar_addr;
  logic [IW-1:0]         cnt, off, ridx;
  logic [1:0]            burst;
  logic                  ic_ok, grant, grant_dc;
  logic                  beat, final_beat, ic_kill, fwd;

`ifdef REFILL_ARBITER_CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(3);
  assign off   = addr_q[IW+1:2];
  assign burst = 2'b10;
`else
  localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  assign off   = '0;
  assign burst = 2'b01;
`endif

  assign ar_addr    = addr_q & MASK;
  assign ic_ok      = ic_req & ~ic_cancel;
  assign grant      = (state == IDLE) & (ic_ok | dc_req);
  assign grant_dc   = dc_req & (~ic_ok | ~last_dc);
  assign beat       = mem_rvalid & mem_rready;
  assign final_beat = beat & (cnt == LAST);
  assign ic_kill    = ic_cancel & ~owner_dc;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (grant) state_nx = ADDR;
      ADDR:  if (mem_arready) state_nx = (drop | ic_kill) ? DRAIN : DATA;
      DATA: begin
        if (final_beat)   state_nx = IDLE;
        else if (ic_kill) state_nx = DRAIN;
      end
      DRAIN: if (final_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_dc  <= 1'b0;
      last_dc   <= 1'b1;
      drop      <= 1'b0;
      addr_q    <= '0;
      cnt       <= '0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      state  <= state_nx;
      ic_ack <= grant & ~grant_dc;
      dc_ack <= grant & grant_dc;
      if (grant) begin
        owner_dc <= grant_dc;
        last_dc  <= grant_dc;
        drop     <= 1'b0;
        addr_q   <= grant_dc ? dc_addr : ic_addr;
      end else if (state == ADDR && ic_kill) begin
        drop <= 1'b1;
      end
      if (beat) cnt <= cnt + 1'b1;
      // termination follows the counter; rlast only feeds the error flag
      if (beat && (mem_rlast != (cnt == LAST))) burst_err <= 1'b1;
    end
  end

  assign busy        = state != IDLE;
  assign mem_arvalid = state == ADDR;
  assign mem_araddr  = mem_arvalid ? ar_addr : '0;
  assign mem_arlen   = mem_arvalid ? 4'(LINE_WORDS - 1) : 4'd0;
  assign mem_arburst = mem_arvalid ? burst : 2'b00;
  assign mem_rready  = (state == DATA) | (state == DRAIN);

  assign fwd  = beat & (state == DATA);
  assign ridx = cnt + off;

  assign ic_rvalid = fwd & ~owner_dc & ~ic_cancel;
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_ridx   = ic_rvalid ? ridx : '0;
  assign ic_rlast  = ic_rvalid & (cnt == LAST);

  assign dc_rvalid = fwd & owner_dc;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_ridx   = dc_rvalid ? ridx : '0;
  assign dc_rlast  = dc_rvalid & (cnt == LAST);

endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: directed and randomized refill bursts
// checked against a line-level reference model.
module tb_refill_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, ic_ack, ic_cancel, ic_rvalid, ic_rlast;
  logic [31:0] ic_addr, ic_rdata;
  logic [2:0]  ic_ridx;
  logic        dc_req, dc_ack, dc_rvalid, dc_rlast;
  logic [31:0] dc_addr, dc_rdata;
  logic [2:0]  dc_ridx;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic [3:0]  mem_arlen;
  logic [1:0]  mem_arburst;
  logic        mem_rvalid, mem_rlast, mem_rready;
  logic [31:0] mem_rdata;
  logic        busy, burst_err;

  int checks = 0;
  int failures = 0;
  bit last_dc = 1'b1;
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  refill_arbiter #(.LINE_WORDS(LW), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .ic_cancel(ic_cancel), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .ic_ridx(ic_ridx), .ic_rlast(ic_rlast),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_ack(dc_ack),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_ridx(dc_ridx), .dc_rlast(dc_rlast),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arburst(mem_arburst),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_rready(mem_rready),
    .busy(busy), .burst_err(burst_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    ic_cancel = 0; mem_rvalid = 0; mem_rlast = 0; mem_arready = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ic_ack, dc_ack}, 0);
    chk("idle_err", burst_err, err_m);
  endtask

  // One complete line refill; cancel_at: -1 none, 0..LW-1 beat, LW = in ADDR
  task automatic do_line(input bit r_ic, input bit r_dc,
                         input logic [31:0] ai, input logic [31:0] ad,
                         input int ar_delay, input int gap_pct,
                         input int cancel_at, input int bad_beat,
                         input bit idle_cancel);
    bit win_ic, v, sup;
    logic [31:0] a, exp_ar, d;
    int off, b, guard;
    logic [1:0] exp_burst;
    @(negedge clk);
    ic_cancel = idle_cancel; mem_rvalid = 0; mem_rlast = 0;
    mem_arready = 0;
    ic_req = ic_req | r_ic; dc_req = dc_req | r_dc;
    ic_addr = ai; dc_addr = ad;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ic_ack, dc_ack}, 0);
    chk("idle_err", burst_err, err_m);
    chk("idle_arvalid", mem_arvalid, 0);
    win_ic = ic_req && !idle_cancel && (!dc_req || last_dc);
    last_dc = !win_ic;
    a = win_ic ? ai : ad;
`ifdef REFILL_ARBITER_CRITICAL_WORD_FIRST_EN
    exp_ar = a & ~32'h3;
    off = int'((a >> 2) % LW);
    exp_burst = 2'b10;
`else
    exp_ar = a & ~32'(LW * 4 - 1);
    off = 0;
    exp_burst = 2'b01;
`endif
    for (int k = 0; k <= ar_delay; k++) begin
      @(negedge clk);
      ic_cancel = (cancel_at == LW) && (k == ar_delay);
      mem_arready = (k == ar_delay);
      if (k > 0) begin
        if (win_ic) ic_req = 0; else dc_req = 0;
      end
      #1;
      chk("ic_ack", ic_ack, win_ic && k == 0);
      chk("dc_ack", dc_ack, !win_ic && k == 0);
      chk("arvalid", mem_arvalid, 1);
      chk("araddr", mem_araddr, exp_ar);
      chk("arlen", mem_arlen, LW - 1);
      chk("arburst", mem_arburst, exp_burst);
      chk("addr_busy", busy, 1);
      chk("addr_rready", mem_rready, 0);
    end
    b = 0; guard = 0;
    while (b < LW && guard < 400) begin
      @(negedge clk);
      guard++;
      if (win_ic) ic_req = 0; else dc_req = 0;
      mem_arready = 0;
      v = $urandom_range(99) >= gap_pct;
      d = $urandom();
      mem_rvalid = v; mem_rdata = d;
      mem_rlast = v && ((b == LW - 1) != (b == bad_beat));
      ic_cancel = v && (b == cancel_at);
      sup = win_ic && cancel_at >= 0 && (cancel_at == LW || b >= cancel_at);
      #1;
      chk("data_arvalid", mem_arvalid, 0);
      chk("data_rready", mem_rready, 1);
      chk("data_ack", {ic_ack, dc_ack}, 0);
      chk("ic_rvalid", ic_rvalid, v && win_ic && !sup);
      chk("dc_rvalid", dc_rvalid, v && !win_ic);
      if (v && !sup) begin
        if (win_ic) begin
          chk("ic_rdata", ic_rdata, d);
          chk("ic_ridx", ic_ridx, (off + b) % LW);
          chk("ic_rlast", ic_rlast, b == LW - 1);
        end else begin
          chk("dc_rdata", dc_rdata, d);
          chk("dc_ridx", dc_ridx, (off + b) % LW);
          chk("dc_rlast", dc_rlast, b == LW - 1);
        end
      end
      if (v) b++;
    end
    if (b < LW) chk("beat_timeout", 0, 1);
    if (bad_beat >= 0) err_m = 1'b1;
  endtask

  initial begin
    rst_n = 0; ic_req = 0; dc_req = 0; ic_cancel = 0;
    ic_addr = 0; dc_addr = 0; mem_arready = 0;
    mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ic_ack, dc_ack}, 0);
    chk("rst_arvalid", mem_arvalid, 0);
    chk("rst_rready", mem_rready, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_rvalid", {ic_rvalid, dc_rvalid}, 0);
    @(negedge clk);
    rst_n = 1;

    do_line(1, 0, 32'h1000_0014, 32'h0, 0, 0, -1, -1, 0);
    idle_check();

    do_line(1, 1, 32'h2000_0040, 32'h3000_0088, 0, 0, -1, -1, 0);
    do_line(0, 0, 32'h0, 32'h3000_0088, 0, 0, -1, -1, 0);
    do_line(1, 1, 32'h2000_0104, 32'h3000_01F8, 1, 0, -1, -1, 0);
    do_line(0, 0, 32'h0, 32'h3000_01F8, 0, 0, -1, -1, 0);
    idle_check();

    do_line(1, 0, 32'h4000_0020, 32'h0, 0, 0, 3, -1, 0);
    do_line(1, 0, 32'h4000_0044, 32'h0, 2, 0, LW, -1, 0);
    do_line(1, 0, 32'h4000_0068, 32'h0, 0, 0, LW - 1, -1, 0);
    do_line(0, 1, 32'h0, 32'h5000_000C, 0, 0, -1, -1, 0);
    do_line(1, 1, 32'h4000_0080, 32'h5000_0030, 0, 0, -1, -1, 1);
    do_line(0, 0, 32'h4000_0080, 32'h0, 0, 0, -1, -1, 0);
    do_line(0, 1, 32'h0, 32'h5000_0050, 0, 0, 2, -1, 0);
    do_line(1, 0, 32'h6000_001C, 32'h0, 5, 40, -1, -1, 0);
    idle_check();

    for (int i = 0; i < 25; i++) begin
      bit ri, rd, ic_c;
      int ca;
      ri = 1'($urandom_range(1));
      rd = 1'($urandom_range(1));
      if (!ri && !rd && !ic_req && !dc_req) ri = 1;
      ic_c = (dc_req || rd) && ($urandom_range(3) == 0);
      ca = int'($urandom_range(LW + 4));
      if (ca > LW) ca = -1;
      do_line(ri, rd, $urandom(), $urandom(), int'($urandom_range(4)),
              int'($urandom_range(60)), ca, -1, ic_c);
    end
    if (ic_req || dc_req)
      do_line(0, 0, $urandom(), $urandom(), 0, 20, -1, -1, 0);
    idle_check();

    do_line(1, 0, 32'h7000_0000, 32'h0, 0, 0, -1, 5, 0);
    idle_check();
    do_line(0, 1, 32'h0, 32'h7000_0100, 0, 30, -1, -1, 0);
    idle_check();

    @(negedge clk);
    ic_req = 1; ic_addr = 32'h8000_0000;
    @(negedge clk);
    mem_arready = 1;
    @(negedge clk);
    ic_req = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_5A5A;
    #1;
    chk("pre_rst_rvalid", ic_rvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rready", mem_rready, 0);
    chk("mid_rst_rvalid", {ic_rvalid, dc_rvalid}, 0);
    chk("mid_rst_rdata", ic_rdata, 0);
    chk("mid_rst_err", burst_err, 0);
    last_dc = 1'b1; err_m = 1'b0;
    @(negedge clk);
    mem_rvalid = 0; rst_n = 1;
    do_line(1, 1, 32'h9000_0024, 32'h9100_0048, 0, 0, -1, -1, 0);
    do_line(0, 0, 32'h0, 32'h9100_0048, 0, 0, -1, LW - 1, 0);
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/refill_arbiter.md
REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 8, 32-bit words per cache line (power of two, 2..16).
REQ-002 Parameter ADDR_WIDTH, default 32, physical address width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ic_req / ic_addr / ic_ack  in / in / out  1 / ADDR_WIDTH / 1  I$ refill request, miss address, one-cycle grant pulse.
REQ-006 ic_cancel  in  1  I$ pipeline flush, cancels pending or granted I$ refill.
REQ-007 ic_rvalid / ic_rdata / ic_ridx / ic_rlast  out / out / out / out  1 / 32 / log2(LINE_WORDS) / 1  I$ refill beat, word index in line, final beat.
REQ-008 dc_req / dc_addr / dc_ack / dc_rvalid / dc_rdata / dc_ridx / dc_rlast  D$ refill port, same widths and meaning as I$; no cancel.
REQ-009 mem_arvalid / mem_arready / mem_araddr / mem_arlen / mem_arburst  out / in / out / out / out  1 / 1 / ADDR_WIDTH / 4 / 2  burst read address channel.
REQ-010 mem_rvalid / mem_rdata / mem_rlast / mem_rready  in / in / in / out  1 / 32 / 1 / 1  burst read data channel.
REQ-011 busy / burst_err  out / out  1 / 1  transaction in flight; sticky rlast/beat-count mismatch flag.

Function
REQ-012 FSM states IDLE, ADDR, DATA, DRAIN; exactly one burst outstanding.
REQ-013 IDLE: any request -> grant, one-cycle ackN pulse, latch owner and address, go ADDR next cycle.
REQ-014 Arbitration round-robin: both requesting -> grant the one not granted last; after reset the last-granted pointer is D$, so I$ wins first.
REQ-015 ic_req with ic_cancel high in the same cycle is not eligible.
REQ-016 ADDR: mem_arvalid=1, mem_arlen=LINE_WORDS-1; address/burst fields per REQ-026/027; hold all AR fields stable until mem_arready; then DATA.
REQ-017 DATA: mem_rready=1; each mem_rvalid beat is forwarded combinationally (zero latency) to the owner's rvalid/rdata; ridx is the beat index, rlast asserted on beat LINE_WORDS-1.
REQ-018 Beat counter counts accepted beats modulo LINE_WORDS; after the final beat, return to IDLE; a new grant may be made in the following cycle.
REQ-019 mem_rlast mismatch (high before final beat or low on final beat): set burst_err; the FSM still ends on counter, not on mem_rlast.
REQ-020 ic_cancel while owner=I$ in ADDR or DATA: go to DRAIN (ADDR completes its handshake first); DRAIN accepts all remaining beats with mem_rready=1, and ic_rvalid stays 0.
REQ-021 ic_cancel in the same cycle as the final beat: suppress that beat's ic_rvalid; next state IDLE.
REQ-022 ic_cancel while owner=D$, or in IDLE: no effect on the current transaction.
REQ-023 busy = state != IDLE.
REQ-024 Requests stay held by the requesters until ack; the arbiter does not queue them.

Reset
REQ-025 rst_n low asynchronously forces IDLE, all outputs 0, beat counter 0, burst_err 0, last-granted = D$; reset asserted mid-burst abandons the burst (memory side is reset together).

Configuration
REQ-026 Macro REFILL_ARBITER_CRITICAL_WORD_FIRST_EN defined: mem_araddr = word-aligned request address, mem_arburst=2'b10 (WRAP), first ridx = address word offset, ridx increments modulo LINE_WORDS; rlast still marks the LINE_WORDS-th beat.
REQ-027 Macro not defined: mem_araddr = line-aligned address, mem_arburst=2'b01 (INCR), ridx runs 0..LINE_WORDS-1.

Verification
REQ-028 Single I$ request, addr 0x1000_0014, arready immediate, 8 beats back-to-back -> ic_ack 1 cycle, araddr 0x1000_0000 (0x1000_0014 with macro), ridx 0..7 (5,6,7,0..4 with macro), ic_rlast on beat 8, busy low afterwards.
REQ-029 ic_req and dc_req both held from reset -> I$ granted first, D$ granted the cycle after I$ final beat, then I$ again.
REQ-030 ic_cancel on DATA beat 3 -> ic_rvalid beats 0..2 only, beats 3..7 drained with rready=1, no dc output, IDLE after beat 8.
REQ-031 mem_rlast asserted on beat 6 -> burst_err=1 and sticky, transfer still ends after beat 8.
REQ-032 arready delayed 5 cycles with random rvalid gaps -> AR fields stable throughout, no beat lost or duplicated.
REQ-033 rst_n pulsed low mid-DATA -> all outputs 0 immediately, state IDLE, next request granted to I$.
